// File: rtl/bsg_chip_pkg.sv
// Shared constants and types for the bsg_link delay-line calibration logic.
package bsg_chip_pkg;

    localparam int unsigned bsg_link_delay_settings_gp = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        RESOLVE
    } bsg_link_delay_tuner_state_e;

endpackage

// File: rtl/bsg_link_delay_center.sv
// Picks the centre of the widest run of passing delay settings for one bit.
module bsg_link_delay_center
    import bsg_chip_pkg::*;
(
    input  logic [bsg_link_delay_settings_gp-1:0] pass_i,
    output logic [1:0]                            sel_o,
    output logic                                  fail_o
);

    int unsigned run_len;
    int unsigned best_len;
    int unsigned best_start;
    logic        in_run;

    // Scan the run length starting at each index; strict '>' keeps the lowest start on ties.
    always_comb begin
        best_len   = 0;
        best_start = 0;
        run_len    = 0;
        in_run     = 1'b0;
        for (int unsigned s = 0; s < bsg_link_delay_settings_gp; s++) begin
            run_len = 0;
            in_run  = 1'b1;
            for (int unsigned k = s; k < bsg_link_delay_settings_gp; k++) begin
                if (in_run && pass_i[k]) run_len++;
                else                     in_run = 1'b0;
            end
            if (run_len > best_len) begin
                best_len   = run_len;
                best_start = s;
            end
        end

        fail_o = (best_len == 0);
        sel_o  = '0;
        if (best_len != 0) sel_o = 2'(best_start + (best_len - 1) / 2);
    end

endmodule

// File: rtl/bsg_link_delay_tuner.sv
// Sweeps the per-bit delay-line selects over all settings against the training
// pattern and commits the centre of each bit's widest passing window.
module bsg_link_delay_tuner
    import bsg_chip_pkg::*;
#(
    parameter int width_p         = 18,
    parameter int settle_cycles_p = 16,
    parameter int sample_cycles_p = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 manual_v_i,
    input  logic [width_p*2-1:0] manual_sel_i,
    input  logic                 valid_i,
    input  logic [width_p-1:0]   data_i,
    input  logic [width_p-1:0]   expected_i,
    output logic [width_p*2-1:0] sel_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [width_p-1:0]   fail_o
);

    localparam int unsigned max_cycles_lp =
        (settle_cycles_p > sample_cycles_p) ? settle_cycles_p : sample_cycles_p;
    localparam int unsigned cnt_width_lp = $clog2(max_cycles_lp + 1);

    localparam logic [cnt_width_lp-1:0] settle_last_lp = cnt_width_lp'(settle_cycles_p - 1);
    localparam logic [cnt_width_lp-1:0] sample_last_lp = cnt_width_lp'(sample_cycles_p - 1);

    bsg_link_delay_tuner_state_e state_r;

    logic [cnt_width_lp-1:0] cnt_r;
    logic [1:0]              setting_r;
    logic [width_p-1:0]      err_r;
    logic                    seen_valid_r;
    logic [width_p-1:0][bsg_link_delay_settings_gp-1:0] pass_r;

    logic [width_p-1:0]      err_next;
    logic                    seen_valid_next;
    logic [width_p-1:0][1:0] center_sel;
    logic [width_p-1:0]      center_fail;

    // Includes the current cycle so the final sample of a window is not lost.
    assign err_next        = err_r | (valid_i ? (data_i ^ expected_i) : '0);
    assign seen_valid_next = seen_valid_r | valid_i;

    for (genvar b = 0; b < width_p; b++) begin : g_center
        bsg_link_delay_center center (
            .pass_i (pass_r[b]),
            .sel_o  (center_sel[b]),
            .fail_o (center_fail[b])
        );
    end

    assign busy_o = (state_r != IDLE);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            setting_r    <= '0;
            err_r        <= '0;
            seen_valid_r <= 1'b0;
            pass_r       <= '0;
            sel_o        <= '0;
            done_o       <= 1'b0;
            fail_o       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        state_r      <= SETTLE;
                        setting_r    <= '0;
                        sel_o        <= '0;
                        done_o       <= 1'b0;
                        cnt_r        <= '0;
                        err_r        <= '0;
                        seen_valid_r <= 1'b0;
                    end else if (manual_v_i) begin
                        sel_o <= manual_sel_i;
                    end
                end
                SETTLE: begin
                    if (cnt_r == settle_last_lp) begin
                        cnt_r   <= '0;
                        state_r <= SAMPLE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cnt_r == sample_last_lp) begin
                        for (int unsigned b = 0; b < width_p; b++)
                            pass_r[b][setting_r] <= seen_valid_next & ~err_next[b];
                        if (setting_r == 2'(bsg_link_delay_settings_gp - 1)) begin
                            state_r <= RESOLVE;
                        end else begin
                            setting_r    <= setting_r + 2'd1;
                            sel_o        <= {width_p{setting_r + 2'd1}};
                            err_r        <= '0;
                            seen_valid_r <= 1'b0;
                            cnt_r        <= '0;
                            state_r      <= SETTLE;
                        end
                    end else begin
                        err_r        <= err_next;
                        seen_valid_r <= seen_valid_next;
                        cnt_r        <= cnt_r + 1'b1;
                    end
                end
                RESOLVE: begin
                    sel_o   <= center_sel;
                    fail_o  <= center_fail;
                    done_o  <= 1'b1;
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
